// File: rtl/sr_cmd_driver.sv
// Queues target bits, pulses s/r into an external SR flop, verifies q with retries; 4 cycles accept->done on first match.
// Backpressure: in_ready = !full; the FSM pops one command only when idle.
module sr_cmd_driver #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       busy,
    output logic       done,
    output logic       done_bit,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  MAX_R   = 4'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, PULSE, CHECK, REPORT} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             cur_q, cur_d;
    logic [3:0]       retry_q, retry_d;
    logic             s_q, s_d, r_q, r_d;
    logic             done_q, done_d, err_q, err_d;
    logic             done_bit_q, done_bit_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             fifo_empty, fifo_full, push, pop, head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        retry_d     = retry_q;
        s_d         = 1'b0;
        r_d         = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        done_bit_d  = done_bit_q;
        err_count_d = err_count_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    retry_d = 4'd0;
                    s_d     = head;
                    r_d     = ~head;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == cur_q) begin
                    done_d     = 1'b1;
                    done_bit_d = cur_q;
                    state_d    = REPORT;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 4'd1;
                    s_d     = cur_q;
                    r_d     = ~cur_q;
                    state_d = PULSE;
                end else begin
                    err_d      = 1'b1;
                    done_bit_d = cur_q;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    state_d    = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= 1'b0;
            retry_q     <= 4'd0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            done_bit_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            retry_q     <= retry_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
            err_q       <= err_d;
            done_bit_q  <= done_bit_d;
            err_count_q <= err_count_d;
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign done_bit  = done_bit_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: SR-flop loopback model (optionally stuck at 0) plus an outcome scoreboard.
module tb_sr_cmd_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       s, r;
    logic       q_fb;
    logic       busy, done, done_bit, err;
    logic [7:0] err_count;

    logic       ff_q;
    logic       stuck = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];
    int         exp_errs = 0;

    sr_cmd_driver #(.DEPTH(4), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .s(s), .r(r), .q_fb(q_fb), .busy(busy),
        .done(done), .done_bit(done_bit), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)  ff_q <= 1'b0;
        else if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : ff_q;

    // Expected outcome entry is {is_err, bit}: a stuck-at-0 flop only verifies 0 targets.
    always @(negedge clk) begin
        logic [1:0] e;
        if (reset) begin
            exp_q.delete();
            exp_errs = 0;
        end else begin
            total++;
            if ((s && r) || (done && err)) begin
                bad++;
                $display("FAIL invariant s=%0b r=%0b done=%0b err=%0b", s, r, done, err);
            end
            if (done || err) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result done=%0b err=%0b bit=%0b required=none", done, err, done_bit);
                end else begin
                    e = exp_q.pop_front();
                    if ({err, done_bit} !== e) begin
                        bad++;
                        $display("FAIL result_order got={err,bit}=%b required=%b", {err, done_bit}, e);
                    end
                end
                if (err && exp_errs < 255) exp_errs++;
                total++;
                if (err_count !== 8'(exp_errs)) begin
                    bad++;
                    $display("FAIL err_count got=%0d required=%0d", err_count, exp_errs);
                end
            end
            if (in_valid && in_ready) exp_q.push_back({stuck && in_bit, in_bit});
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout busy=%0b pending=%0d required=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({s, r, done, err, done_bit, busy, in_ready, err_count} !== {7'b0000001, 8'd0}) begin
            bad++;
            $display("FAIL reset_state s=%0b r=%0b done=%0b err=%0b bit=%0b busy=%0b rdy=%0b cnt=%0d required rdy=1 others=0",
                     s, r, done, err, done_bit, busy, in_ready, err_count);
        end
    endtask

    task automatic test_single();
        stuck = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_bit = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (s !== (k == 2) || r !== 1'b0 || done !== (k == 4) || (k == 4 && done_bit !== 1'b1)) begin
                bad++;
                $display("FAIL single cyc=%0d s=%0b r=%0b done=%0b bit=%0b required s=%0b r=0 done=%0b bit=1",
                         k, s, r, done, done_bit, k == 2, k == 4);
            end
        end
        wait_idle(50);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat = 8'b0000_0101;
        logic exp_s, exp_r, exp_d;
        stuck = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_bit = pat[0];
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 4);
            in_bit = pat[k];
            @(negedge clk);
            exp_s = (k % 4 == 2) && (k <= 14) && ((k / 4) % 2 == 0);
            exp_r = (k % 4 == 2) && (k <= 14) && ((k / 4) % 2 == 1);
            exp_d = (k % 4 == 0) && (k >= 4) && (k <= 16);
            total++;
            if (s !== exp_s || r !== exp_r || done !== exp_d || (k < 4 && in_ready !== 1'b1)) begin
                bad++;
                $display("FAIL b2b cyc=%0d s=%0b r=%0b done=%0b rdy=%0b required s=%0b r=%0b done=%0b",
                         k, s, r, done, in_ready, exp_s, exp_r, exp_d);
            end
        end
        wait_idle(50);
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL b2b_err_count got=%0d required=0", err_count);
        end
    endtask

    task automatic test_stuck_retry();
        logic exp_s;
        stuck = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_bit = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            exp_s = (k == 2) || (k == 4) || (k == 6) || (k == 8);
            total++;
            if (s !== exp_s || r !== 1'b0 || done !== 1'b0 || err !== (k == 10) || (k == 10 && done_bit !== 1'b1)) begin
                bad++;
                $display("FAIL retry cyc=%0d s=%0b r=%0b done=%0b err=%0b bit=%0b required s=%0b err=%0b",
                         k, s, r, done, err, done_bit, exp_s, k == 10);
            end
        end
        total++;
        if (err_count !== 8'd1) begin
            bad++;
            $display("FAIL retry_err_count got=%0d required=1", err_count);
        end
        wait_idle(50);
    endtask

    task automatic test_fill();
        logic [15:0] pat = 16'b0001_0101;
        logic exp_rdy;
        stuck = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_bit = pat[0];
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 5);
            in_bit = pat[k];
            @(negedge clk);
            exp_rdy = !((k >= 5) && (k <= 11));
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL fill_ready cyc=%0d got=%0b required=%0b", k, in_ready, exp_rdy);
            end
        end
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat = 8'b0000_0101;
        stuck = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_bit = pat[0];
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 3);
            in_bit = pat[k];
            if (k == 4) reset = 1'b1;
            @(negedge clk);
        end
        total++;
        if (s !== 1'b1) begin
            bad++;
            $display("FAIL mid_pulse_before_reset s=%0b required=1", s);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({s, r, busy, in_ready, done, err, err_count} !== {6'b000100, 8'd0}) begin
            bad++;
            $display("FAIL mid_reset s=%0b r=%0b busy=%0b rdy=%0b done=%0b err=%0b cnt=%0d required rdy=1 others=0",
                     s, r, busy, in_ready, done, err, err_count);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_after cyc=%0d done=%0b err=%0b busy=%0b required=0", k, done, err, busy);
            end
        end
    endtask

    task automatic test_saturate();
        int accepted = 0;
        int n = 0;
        logic rdy_now;
        stuck = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_bit = 1'b1;
        while (accepted < 260 && n < 5000) begin
            @(negedge clk);
            rdy_now = in_ready;
            @(posedge clk); #1;
            if (rdy_now) accepted++;
            if (accepted >= 260) in_valid = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (accepted != 260) begin
            bad++;
            $display("FAIL sat_accept got=%0d required=260", accepted);
        end
        wait_idle(200);
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL sat_err_count got=%0d required=255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stuck_retry();
        test_fill();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
